// File: rtl/oram_backend_pkg.sv
// Shared definitions for the Path ORAM backend command interface:
// command encodings, the dummy-access address, the dummy-leaf LFSR
// polynomial and the rate controller state encoding.
package oram_backend_pkg;

   localparam logic [1:0] BECMD_Update  = 2'd0;
   localparam logic [1:0] BECMD_Append  = 2'd1;
   localparam logic [1:0] BECMD_Read    = 2'd2;
   localparam logic [1:0] BECMD_ReadRmv = 2'd3;

   // All-ones address marks a dummy path access; users slice it to ORAMU bits.
   localparam int         DUMMY_PADDR_W = 64;
   localparam logic [DUMMY_PADDR_W-1:0] DUMMY_PADDR = '1;

   // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_ISSUE = 1'b1
   } rate_state_e;

endpackage

// File: rtl/oram_lfsr32.sv
// 32-bit Galois LFSR used to draw random leaves for dummy path accesses.
// Steps once per cycle while Enable is high; Out is the current state.
module oram_lfsr32
   import oram_backend_pkg::*;
#(
   parameter logic [31:0] Seed = 32'hACE1_0001
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   output logic [31:0] Out
);

   logic [31:0] lfsr_q, lfsr_d;

   // Next state: shift right, fold taps in when the bit shifted out is set.
   always_comb begin
      lfsr_d = lfsr_q;
      if (Enable) begin
         lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
      end
   end

   // State register, reloaded with the seed on reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         lfsr_q <= Seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign Out = lfsr_q;

endmodule

// File: rtl/oram_access_rate_ctrl.sv
// ORAM access rate controller: admits backend commands no closer than
// Interval cycles after the previous backend handshake, with one command
// in flight. Define ORAM_RATE_DUMMY_EN to inject dummy path reads whenever
// a slot opens with no frontend request, making the access rate periodic.
module oram_access_rate_ctrl
   import oram_backend_pkg::*;
#(
   parameter int          ORAMU         = 32,
   parameter int          ORAML         = 10,
   parameter int          BECMDWidth    = 2,
   parameter int          Interval      = 100,
   parameter int          IntervalWidth = 16,
   parameter logic [31:0] LFSRSeed      = 32'hACE1_0001
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [BECMDWidth-1:0] FE_Command,
   input  logic [ORAMU-1:0]      FE_PAddr,
   input  logic [ORAML-1:0]      FE_CurrentLeaf,
   input  logic [ORAML-1:0]      FE_RemappedLeaf,
   input  logic                  FE_CommandValid,
   output logic                  FE_CommandReady,
   output logic [BECMDWidth-1:0] BE_Command,
   output logic [ORAMU-1:0]      BE_PAddr,
   output logic [ORAML-1:0]      BE_CurrentLeaf,
   output logic [ORAML-1:0]      BE_RemappedLeaf,
   output logic                  BE_IsDummy,
   output logic                  BE_CommandValid,
   input  logic                  BE_CommandReady
);

   localparam logic [IntervalWidth-1:0] INTERVAL_C = IntervalWidth'(Interval);

   rate_state_e               state_q, state_d;
   logic [IntervalWidth-1:0]  cnt_q, cnt_d;
   logic [BECMDWidth-1:0]     cmd_q, cmd_d;
   logic [ORAMU-1:0]          paddr_q, paddr_d;
   logic [ORAML-1:0]          cur_q, cur_d;
   logic [ORAML-1:0]          rem_q, rem_d;
   logic                      slot_open;

`ifdef ORAM_RATE_DUMMY_EN
   logic                      dummy_q, dummy_d;
   logic                      lfsr_en;
   logic [31:0]               lfsr_out;

   oram_lfsr32 #(
      .Seed   (LFSRSeed)
   ) u_lfsr (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (lfsr_en),
      .Out    (lfsr_out)
   );
`endif

   // A slot is open only in WAIT with the spacing counter saturated.
   assign slot_open = (state_q == ST_WAIT) && (cnt_q == INTERVAL_C);

   // Next-state logic: count spacing, capture a real (or dummy) command
   // into the output registers, hold it until the backend handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      paddr_d = paddr_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
`ifdef ORAM_RATE_DUMMY_EN
      dummy_d = dummy_q;
      lfsr_en = 1'b0;
`endif
      case (state_q)
         ST_WAIT: begin
            if (cnt_q != INTERVAL_C) begin
               cnt_d = cnt_q + IntervalWidth'(1);
            end
            if (slot_open) begin
               if (FE_CommandValid) begin
                  cmd_d   = FE_Command;
                  paddr_d = FE_PAddr;
                  cur_d   = FE_CurrentLeaf;
                  rem_d   = FE_RemappedLeaf;
`ifdef ORAM_RATE_DUMMY_EN
                  dummy_d = 1'b0;
`endif
                  state_d = ST_ISSUE;
               end
`ifdef ORAM_RATE_DUMMY_EN
               else begin
                  // Idle slot: issue a read of a random path so the
                  // backend sees the same access pattern either way.
                  cmd_d   = BECMDWidth'(BECMD_Read);
                  paddr_d = DUMMY_PADDR[ORAMU-1:0];
                  cur_d   = lfsr_out[ORAML-1:0];
                  rem_d   = lfsr_out[ORAML-1:0];
                  dummy_d = 1'b1;
                  lfsr_en = 1'b1;
                  state_d = ST_ISSUE;
               end
`endif
            end
         end
         ST_ISSUE: begin
            // Counter stays frozen while the backend stalls.
            if (BE_CommandReady) begin
               cnt_d   = IntervalWidth'(1);
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // State, counter and output registers; reset opens the first slot at once.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_WAIT;
         cnt_q   <= INTERVAL_C;
         cmd_q   <= '0;
         paddr_q <= '0;
         cur_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         paddr_q <= paddr_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
      end
   end

`ifdef ORAM_RATE_DUMMY_EN
   // Dummy flag travels with the captured command.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         dummy_q <= 1'b0;
      end else begin
         dummy_q <= dummy_d;
      end
   end

   assign BE_IsDummy = dummy_q;
`else
   assign BE_IsDummy = 1'b0;
`endif

   assign FE_CommandReady = slot_open;
   assign BE_CommandValid = (state_q == ST_ISSUE);
   assign BE_Command      = cmd_q;
   assign BE_PAddr        = paddr_q;
   assign BE_CurrentLeaf  = cur_q;
   assign BE_RemappedLeaf = rem_q;

endmodule

// File: tb/tb_oram_access_rate_ctrl.sv
// Testbench for oram_access_rate_ctrl with Interval = 8. A negedge monitor
// keeps a scoreboard of expected backend commands (real requests pushed on
// the frontend handshake, dummies predicted by a reference LFSR when
// ORAM_RATE_DUMMY_EN is defined) and logs handshake cycles for the
// timing checks done in the scenario tasks.
module tb_oram_access_rate_ctrl;

   localparam int          ORAMU  = 32;
   localparam int          ORAML  = 10;
   localparam int          BECMDW = 2;
   localparam int          INTV   = 8;
   localparam logic [31:0] SEED   = 32'hACE1_0001;

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic [BECMDW-1:0] FE_Command = '0;
   logic [ORAMU-1:0]  FE_PAddr = '0;
   logic [ORAML-1:0]  FE_CurrentLeaf = '0;
   logic [ORAML-1:0]  FE_RemappedLeaf = '0;
   logic              FE_CommandValid = 1'b0;
   logic              FE_CommandReady;
   logic [BECMDW-1:0] BE_Command;
   logic [ORAMU-1:0]  BE_PAddr;
   logic [ORAML-1:0]  BE_CurrentLeaf;
   logic [ORAML-1:0]  BE_RemappedLeaf;
   logic              BE_IsDummy;
   logic              BE_CommandValid;
   logic              BE_CommandReady = 1'b1;

   typedef struct packed {
      logic [BECMDW-1:0] cmd;
      logic [ORAMU-1:0]  paddr;
      logic [ORAML-1:0]  cur;
      logic [ORAML-1:0]  rem;
      logic              dummy;
   } exp_t;

   exp_t        sb[$];
   int          fe_hs[$];
   int          be_hs[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] lfsr_m = SEED;

   oram_access_rate_ctrl #(
      .ORAMU         (ORAMU),
      .ORAML         (ORAML),
      .BECMDWidth    (BECMDW),
      .Interval      (INTV),
      .IntervalWidth (16),
      .LFSRSeed      (SEED)
   ) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .FE_Command      (FE_Command),
      .FE_PAddr        (FE_PAddr),
      .FE_CurrentLeaf  (FE_CurrentLeaf),
      .FE_RemappedLeaf (FE_RemappedLeaf),
      .FE_CommandValid (FE_CommandValid),
      .FE_CommandReady (FE_CommandReady),
      .BE_Command      (BE_Command),
      .BE_PAddr        (BE_PAddr),
      .BE_CurrentLeaf  (BE_CurrentLeaf),
      .BE_RemappedLeaf (BE_RemappedLeaf),
      .BE_IsDummy      (BE_IsDummy),
      .BE_CommandValid (BE_CommandValid),
      .BE_CommandReady (BE_CommandReady)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Scoreboard monitor, sampled on the inactive edge.
   always @(negedge Clock) begin
      exp_t e;
      exp_t got;
      if (Reset) begin
         sb.delete();
         lfsr_m = SEED;
      end else begin
         if (BE_CommandValid && BE_CommandReady) begin
            be_hs.push_back(cyc);
            vectors++;
            got = '{BE_Command, BE_PAddr, BE_CurrentLeaf, BE_RemappedLeaf, BE_IsDummy};
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL be_unexpected cyc=%0d got cmd=%0d paddr=%h dummy=%0d required no command",
                        cyc, BE_Command, BE_PAddr, BE_IsDummy);
            end else begin
               e = sb.pop_front();
               if (got !== e) begin
                  miscompares++;
                  $display("FAIL be_cmd cyc=%0d got cmd=%0d paddr=%h cur=%h rem=%h dummy=%0d required cmd=%0d paddr=%h cur=%h rem=%h dummy=%0d",
                           cyc, got.cmd, got.paddr, got.cur, got.rem, got.dummy,
                           e.cmd, e.paddr, e.cur, e.rem, e.dummy);
               end
            end
         end
         if (FE_CommandReady && FE_CommandValid) begin
            fe_hs.push_back(cyc);
            sb.push_back('{FE_Command, FE_PAddr, FE_CurrentLeaf, FE_RemappedLeaf, 1'b0});
         end
`ifdef ORAM_RATE_DUMMY_EN
         else if (FE_CommandReady) begin
            sb.push_back('{2'd2, {ORAMU{1'b1}}, lfsr_m[ORAML-1:0], lfsr_m[ORAML-1:0], 1'b1});
            lfsr_m = lfsr_step(lfsr_m);
         end
`endif
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      FE_CommandValid = 1'b0;
      BE_CommandReady = 1'b1;
      step();
      step();
      fe_hs.delete();
      be_hs.delete();
      Reset = 1'b0;
   endtask

   task automatic send_fe(input logic [1:0] c, input logic [31:0] a,
                          input logic [9:0] cl, input logic [9:0] rl, output int hs);
      FE_Command = c;
      FE_PAddr = a;
      FE_CurrentLeaf = cl;
      FE_RemappedLeaf = rl;
      FE_CommandValid = 1'b1;
      hs = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (FE_CommandReady) begin
            hs = cyc;
            step();
            FE_CommandValid = 1'b0;
            return;
         end
         step();
      end
      FE_CommandValid = 1'b0;
      vectors++;
      miscompares++;
      $display("FAIL fe_timeout got no FE_CommandReady in 40 cycles required a handshake");
   endtask

   task automatic wait_be(input int n);
      for (int i = 0; i < 40; i++) begin
         if (be_hs.size() >= n) return;
         step();
      end
      vectors++;
      miscompares++;
      $display("FAIL be_timeout got %0d backend handshakes required %0d", be_hs.size(), n);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      FE_CommandValid = 1'b0;
      step();
      step();
      @(negedge Clock);
      vectors++;
      if (FE_CommandReady !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_fe_ready got %b required 1", FE_CommandReady);
      end
      vectors++;
      if (BE_CommandValid !== 1'b0 || BE_IsDummy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_be_flags got valid=%b dummy=%b required 0 0", BE_CommandValid, BE_IsDummy);
      end
      vectors++;
      if (BE_Command !== '0 || BE_PAddr !== '0 || BE_CurrentLeaf !== '0 || BE_RemappedLeaf !== '0) begin
         miscompares++;
         $display("FAIL reset_be_fields got cmd=%0d paddr=%h cur=%h rem=%h required all 0",
                  BE_Command, BE_PAddr, BE_CurrentLeaf, BE_RemappedLeaf);
      end
   endtask

   task automatic test_first_cmd();
      step();
      BE_CommandReady = 1'b1;
      FE_Command = 2'd1;
      FE_PAddr = 32'h0000_1234;
      FE_CurrentLeaf = 10'h155;
      FE_RemappedLeaf = 10'h2AA;
      FE_CommandValid = 1'b1;
      fe_hs.delete();
      be_hs.delete();
      Reset = 1'b0;
      @(negedge Clock);
      vectors++;
      if (FE_CommandReady !== 1'b1) begin
         miscompares++;
         $display("FAIL first_slot got FE_CommandReady=%b required 1", FE_CommandReady);
      end
      step();
      FE_CommandValid = 1'b0;
      @(negedge Clock);
      vectors++;
      if (BE_CommandValid !== 1'b1 || BE_PAddr !== 32'h0000_1234 || BE_IsDummy !== 1'b0) begin
         miscompares++;
         $display("FAIL first_issue got valid=%b paddr=%h dummy=%b required 1 00001234 0",
                  BE_CommandValid, BE_PAddr, BE_IsDummy);
      end
      step();
      step();
   endtask

   task automatic test_back_to_back();
      int h0;
      int h1;
      do_reset();
      send_fe(2'd0, 32'h0000_AAAA, 10'h011, 10'h022, h0);
      send_fe(2'd1, 32'h0000_BBBB, 10'h033, 10'h044, h1);
      wait_be(2);
      if (be_hs.size() >= 2) begin
         vectors++;
         if (be_hs[0] !== h0 + 1) begin
            miscompares++;
            $display("FAIL b2b_latency got be_hs=%0d required %0d", be_hs[0], h0 + 1);
         end
         vectors++;
         if (h1 - be_hs[0] !== INTV) begin
            miscompares++;
            $display("FAIL b2b_slot_gap got %0d required %0d", h1 - be_hs[0], INTV);
         end
         vectors++;
         if (be_hs[1] - be_hs[0] !== INTV + 1) begin
            miscompares++;
            $display("FAIL b2b_hs_gap got %0d required %0d", be_hs[1] - be_hs[0], INTV + 1);
         end
      end
   endtask

   task automatic test_dummy();
      do_reset();
      repeat (50) step();
`ifdef ORAM_RATE_DUMMY_EN
      vectors++;
      if (be_hs.size() < 5) begin
         miscompares++;
         $display("FAIL dummy_count got %0d required at least 5", be_hs.size());
      end
      for (int i = 1; i < be_hs.size(); i++) begin
         vectors++;
         if (be_hs[i] - be_hs[i-1] !== INTV + 1) begin
            miscompares++;
            $display("FAIL dummy_period got %0d required %0d", be_hs[i] - be_hs[i-1], INTV + 1);
         end
      end
`else
      @(negedge Clock);
      vectors++;
      if (be_hs.size() !== 0) begin
         miscompares++;
         $display("FAIL idle_no_cmd got %0d handshakes required 0", be_hs.size());
      end
      vectors++;
      if (FE_CommandReady !== 1'b1 || BE_CommandValid !== 1'b0 || BE_IsDummy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_slot got ready=%b valid=%b dummy=%b required 1 0 0",
                  FE_CommandReady, BE_CommandValid, BE_IsDummy);
      end
      step();
`endif
   endtask

   task automatic test_stall();
      int h;
      int hs;
      int rise;
      do_reset();
      BE_CommandReady = 1'b0;
      send_fe(2'd3, 32'hDEAD_BEEF, 10'h3FF, 10'h001, h);
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         vectors++;
         if (BE_CommandValid !== 1'b1 || BE_PAddr !== 32'hDEAD_BEEF || BE_Command !== 2'd3 ||
             BE_CurrentLeaf !== 10'h3FF || BE_RemappedLeaf !== 10'h001 || FE_CommandReady !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got valid=%b paddr=%h cmd=%0d cur=%h rem=%h ready=%b required 1 deadbeef 3 3ff 001 0",
                     cyc, BE_CommandValid, BE_PAddr, BE_Command, BE_CurrentLeaf, BE_RemappedLeaf, FE_CommandReady);
         end
         step();
      end
      BE_CommandReady = 1'b1;
      @(negedge Clock);
      hs = cyc;
      step();
      rise = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clock);
         if (FE_CommandReady) begin
            rise = cyc;
            break;
         end
         step();
      end
      vectors++;
      if (rise - hs !== INTV) begin
         miscompares++;
         $display("FAIL stall_resume got slot %0d cycles after handshake required %0d", rise - hs, INTV);
      end
      step();
   endtask

   task automatic test_real_wins();
      int h0;
      int h1;
      int hb;
      do_reset();
      send_fe(2'd0, 32'h0000_5555, 10'h0F0, 10'h00F, h0);
      wait_be(1);
      hb = (be_hs.size() > 0) ? be_hs[0] : cyc;
      for (int i = 0; i < 40 && cyc < hb + INTV - 1; i++) step();
      @(negedge Clock);
      vectors++;
      if (FE_CommandReady !== 1'b0) begin
         miscompares++;
         $display("FAIL race_pre_slot got FE_CommandReady=%b required 0", FE_CommandReady);
      end
      step();
      FE_Command = 2'd1;
      FE_PAddr = 32'h0000_7777;
      FE_CurrentLeaf = 10'h123;
      FE_RemappedLeaf = 10'h321;
      FE_CommandValid = 1'b1;
      @(negedge Clock);
      vectors++;
      if (FE_CommandReady !== 1'b1) begin
         miscompares++;
         $display("FAIL race_slot got FE_CommandReady=%b required 1", FE_CommandReady);
      end
      h1 = cyc;
      step();
      FE_CommandValid = 1'b0;
      @(negedge Clock);
      vectors++;
      if (BE_CommandValid !== 1'b1 || BE_IsDummy !== 1'b0 || BE_PAddr !== 32'h0000_7777 || h1 - hb !== INTV) begin
         miscompares++;
         $display("FAIL race_real got valid=%b dummy=%b paddr=%h gap=%0d required 1 0 00007777 %0d",
                  BE_CommandValid, BE_IsDummy, BE_PAddr, h1 - hb, INTV);
      end
`ifdef ORAM_RATE_DUMMY_EN
      wait_be(4);
`else
      step();
`endif
   endtask

   task automatic test_reset_mid_issue();
      int h;
      do_reset();
      BE_CommandReady = 1'b0;
      send_fe(2'd2, 32'h0BAD_F00D, 10'h2B2, 10'h1C1, h);
      @(negedge Clock);
      vectors++;
      if (BE_CommandValid !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre got BE_CommandValid=%b required 1", BE_CommandValid);
      end
      step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      BE_CommandReady = 1'b1;
      @(negedge Clock);
      vectors++;
      if (BE_CommandValid !== 1'b0 || FE_CommandReady !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_post got valid=%b ready=%b required 0 1", BE_CommandValid, FE_CommandReady);
      end
      repeat (12) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no completion required finish before 200000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_cmd();
      test_back_to_back();
      test_dummy();
      test_stall();
      test_real_wins();
      test_reset_mid_issue();
      Reset = 1'b1;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/oram_access_rate_ctrl.md
# oram_access_rate_ctrl

Sits between the ORAM frontend and the Path ORAM backend command port. It admits backend commands at a fixed minimum spacing, so the DRAM access rate does not depend on program behaviour. When a slot opens and no real request is waiting, it can inject a dummy path access. All outputs are registered; the backend sees one command in flight at a time.

## Interface
Parameters:
- ORAMU, 32: physical block address width.
- ORAML, 10: leaf label width (≤ 32).
- BECMDWidth, 2: backend command width.
- Interval, 100: minimum cycles from one backend command handshake to the next slot opening (≥ 1).
- IntervalWidth, 16: width of the spacing counter (must hold Interval).
- LFSRSeed, 32'hACE1_0001: dummy-leaf LFSR seed (nonzero).

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- FE_Command  in  BECMDWidth  frontend command
- FE_PAddr  in  ORAMU  frontend address
- FE_CurrentLeaf  in  ORAML  current leaf
- FE_RemappedLeaf  in  ORAML  new leaf
- FE_CommandValid  in  1  frontend request valid
- FE_CommandReady  out  1  slot open, request accepted
- BE_Command  out  BECMDWidth  issued command
- BE_PAddr  out  ORAMU  issued address
- BE_CurrentLeaf  out  ORAML  issued current leaf
- BE_RemappedLeaf  out  ORAML  issued remapped leaf
- BE_IsDummy  out  1  issued command is a dummy
- BE_CommandValid  out  1  command valid to backend
- BE_CommandReady  in  1  backend accepts command

## Operation
- State machine with two states, WAIT and ISSUE. Reset enters WAIT with Cnt = Interval, so the first slot opens immediately.
- WAIT:
  - Cnt increments each cycle and saturates at Interval.
  - The slot is open when Cnt == Interval.
  - FE_CommandReady = (state == WAIT) && (Cnt == Interval). It is combinational from state and counter only, never from FE_CommandValid.
- Slot open with FE_CommandValid = 1:
  - Capture the frontend fields into the output registers.
  - Set BE_IsDummy = 0.
  - Go to ISSUE.
- Slot open with FE_CommandValid = 0 (dummy mode only):
  - Load BE_Command = BECMD_Read and BE_PAddr = DUMMY_PADDR (all ones).
  - Load BE_CurrentLeaf = BE_RemappedLeaf = LFSR[ORAML-1:0].
  - Set BE_IsDummy = 1, advance the LFSR one step, go to ISSUE.
- A real request present in the open-slot cycle always wins over a dummy.
- ISSUE:
  - BE_CommandValid = 1 and the output registers are held stable.
  - On BE_CommandValid && BE_CommandReady: Cnt ← 1, go to WAIT.
- BE_CommandReady outside ISSUE is ignored.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, loaded with LFSRSeed on reset. It advances only on dummy capture.

## Timing
- Reset values:
  - FE_CommandReady = 1 (slot open).
  - BE_CommandValid = 0, BE_IsDummy = 0.
  - BE_Command, BE_PAddr and both BE leaves = 0.
  - Cnt = Interval, LFSR = LFSRSeed.
- Frontend handshake at cycle t → BE_CommandValid = 1 at t+1 (one-cycle latency).
- Backend handshake at cycle t → the earliest next slot opens at t+Interval. Handshake-to-handshake spacing is at least Interval+1 cycles.
- In dummy mode with the backend always ready, backend handshakes are periodic with period exactly Interval+1.
- Backend stall: while ISSUE waits on BE_CommandReady, Cnt is frozen and no new slot opens.
- Reset asserted mid-ISSUE: the captured command is discarded and BE_CommandValid = 0 on the next cycle. The backend must be reset in the same cycle.
- Interval = 1: slots open on alternate cycles at most; no special case.

## Configuration
- ORAM_RATE_DUMMY_EN defined: dummy injection is enabled as described above. Backend commands are strictly periodic under a ready backend.
- ORAM_RATE_DUMMY_EN undefined:
  - No dummies; BE_IsDummy is tied to 0 and the LFSR is not instantiated.
  - An open slot stays open, with Cnt saturated, until FE_CommandValid arrives. The block then enforces minimum spacing only.

## Structure
- Shared package oram_backend_pkg holds:
  - BECMD_* command encodings, including BECMD_Read.
  - DUMMY_PADDR (all-ones at ORAMU width).
  - The LFSR polynomial constant.
  - The WAIT/ISSUE state encoding.
- One sub-module: oram_lfsr32, a 32-bit Galois LFSR with Seed parameter, Clock, Reset, Enable and a 32-bit Out port.
- The counter, FSM and output registers live in the top module.

## Test plan
- Reset, then FE_CommandValid with PAddr 0x1234, Interval = 8, backend ready → FE_CommandReady = 1 in the first cycle; BE_CommandValid at +1 with PAddr 0x1234 and BE_IsDummy = 0.
- Two back-to-back frontend requests, Interval = 8, backend always ready → the second FE_CommandReady rises exactly 8 cycles after the first backend handshake.
- Dummy mode, no frontend traffic for 50 cycles, Interval = 8 → backend handshakes every 9 cycles. Each has PAddr all-ones, IsDummy = 1, and leaves equal to successive LFSR values starting from the seed step.
- Backend holds BE_CommandReady = 0 for 20 cycles in ISSUE → outputs are stable, FE_CommandReady = 0 throughout, and Cnt resumes only after the handshake.
- FE_CommandValid rises in the same cycle the slot opens, dummy mode → a real command is issued and the LFSR does not advance.
- Reset asserted while BE_CommandValid = 1 → BE_CommandValid = 0 next cycle and FE_CommandReady = 1.
